nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_in  input  W  operand A.
REQ-005 b_in  input  W  operand B.
REQ-006 c_in  input  1  carry-in to least-significant nibble.
REQ-007 in_valid  input  1  operands valid.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 sum_out  output  W  result.
REQ-010 cout_out  output  1  carry out of the most-significant nibble.
REQ-011 ovf_out  output  1  signed (two's-complement) overflow.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on in_valid&&in_ready, latch a_in, b_in, c_in into operand registers, clear nibble index to 0, go to RUN.
REQ-016 RUN: each cycle add nibble[idx] of A and B plus the carry register; write the 4-bit result into sum nibble idx; store carry-out in the carry register; idx increments by 1.
REQ-017 RUN: when idx == NIBBLES-1 the nibble completes, then go to DONE; idx SHALL never wrap past NIBBLES-1.
REQ-018 Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (4 cycles at default).
REQ-019 DONE: out_valid = 1; sum_out, cout_out and ovf_out SHALL be held stable until out_valid&&out_ready, then go to IDLE.
REQ-020 No same-cycle accept in DONE; minimum throughput is one result per NIBBLES+2 cycles.
REQ-021 ovf_out = carry into MSB XOR carry out of MSB, captured on the final nibble.
REQ-022 Operand inputs and in_valid changes outside IDLE SHALL be ignored.
REQ-023 The result equals (A + B + c_in) mod 2^W, with cout_out = bit W of the full sum.

Reset
REQ-024 rst_n low, asynchronous: state = IDLE; sum_out = 0; cout_out = 0; ovf_out = 0; out_valid = 0; carry register = 0; idx = 0; operand registers = 0.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort the operation with no partial result visible; in_ready = 1 from the first edge after deassertion.

Configuration
REQ-026 Macro NIBBLE_SERIAL_ADDER_SUB_EN: when defined, add port sub_in (input, 1, sampled with the operands).
REQ-027 When sub_in = 1, B is stored inverted and the initial carry is 1, ignoring c_in; the result is A - B and cout_out = 1 means no borrow.
REQ-028 When the macro is undefined, port sub_in is absent and behaviour is add-only per REQ-023.

Structure
REQ-029 Shared package nibble_add_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constant NIBBLE_W = 4.
REQ-030 One combinational sub-module, nibble_add4, SHALL perform the per-cycle 4-bit add: inputs a[3:0], b[3:0], ci; outputs s[3:0], co, and the MSB carry-in c3 for overflow.

Verification
REQ-031 0xB7A3 + 0x7F5E, c_in = 0 -> sum 0x3701, cout 1, ovf 0; out_valid exactly 4 cycles after accept.
REQ-032 0xFFFF + 0x0001, c_in = 0 -> sum 0x0000, cout 1 (full ripple); 0x000F + 0x0000, c_in = 1 -> sum 0x0010, cout 0.
REQ-033 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0, and new in_valid pulses are ignored; the result is released on the first out_ready = 1.
REQ-035 rst_n pulsed low during RUN cycle 2 -> all outputs 0 immediately; the next operation 0x1234 + 0x1111 -> 0x2345.
REQ-036 With NIBBLE_SERIAL_ADDER_SUB_EN defined: 0x0005 - 0x0007 -> sum 0xFFFE, cout 0; 0x0007 - 0x0005 -> 0x0002, cout 1.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional subtract mode is enabled by NIBBLE_SERIAL_ADDER_SUB_EN.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index, kept at least one bit for NIBBLES == 1.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// sub_in exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    import nibble_add_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;
    logic         out_valid;
    logic         out_ready;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub_in;

    modport master (
        output a_in, b_in, c_in, sub_in, in_valid, out_ready,
        input  in_ready, sum_out, cout_out, ovf_out, out_valid
    );

    modport slave (
        input  a_in, b_in, c_in, sub_in, in_valid, out_ready,
        output in_ready, sum_out, cout_out, ovf_out, out_valid
    );
`else
    modport master (
        output a_in, b_in, c_in, in_valid, out_ready,
        input  in_ready, sum_out, cout_out, ovf_out, out_valid
    );

    modport slave (
        input  a_in, b_in, c_in, in_valid, out_ready,
        output in_ready, sum_out, cout_out, ovf_out, out_valid
    );
`endif

endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit adder slice; exposes the carry into bit 3 so the
// caller can derive signed overflow on the top nibble.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] low_sum;
    logic [1:0] high_sum;

    assign low_sum  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
    assign c3       = low_sum[3];
    assign high_sum = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};

    assign s  = {high_sum[0], low_sum[2:0]};
    assign co = high_sum[1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit digit per cycle, LSB first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub_in (A - B) mode.
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              accept;
    logic              last_nibble;
    logic [3:0]        nib_a, nib_b, nib_s;
    logic              nib_co, nib_c3;

    assign accept      = (state_q == IDLE) && bus.in_valid;
    assign last_nibble = (idx_q == LAST_IDX);
    assign nib_a       = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign nib_b       = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    nibble_add4 u_add4 (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = RUN;
            RUN:     if (last_nibble)    state_d = DONE;
            DONE:    if (bus.out_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction reuses the adder: A + ~B + 1, so cout = 1 means no borrow.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = bus.a_in;
                    idx_d = '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                    if (bus.sub_in) begin
                        b_d     = ~bus.b_in;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = bus.b_in;
                        carry_d = bus.c_in;
                    end
`else
                    b_d     = bus.b_in;
                    carry_d = bus.c_in;
`endif
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = nib_s;
                carry_d = nib_co;
                if (last_nibble) begin
                    cout_d = nib_co;
                    ovf_d  = nib_c3 ^ nib_co;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.sum_out  = sum_q;
    assign bus.cout_out = cout_q;
    assign bus.ovf_out  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised self-checking bench for nibble_serial_adder against an
// arithmetic reference model; covers NIBBLE_SERIAL_ADDER_SUB_EN when defined.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sub);
        longint ua, ub, sa, sb, ures, sres;
        logic [W-1:0] sum;
        logic cout, ovf;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            cout = (ua >= ub);
        end else begin
            ures = ua + ub + longint'(cin);
            sres = sa + sb + longint'(cin);
            cout = (ures >= (64'sd1 <<< W));
        end
        sum = ures[W-1:0];
        ovf = (sres > ((64'sd1 <<< (W-1)) - 1)) || (sres < -(64'sd1 <<< (W-1)));
        return {ovf, cout, sum};
    endfunction

    task automatic driveJunk(input logic valid);
        bus.a_in     = W'($urandom);
        bus.b_in     = W'($urandom);
        bus.c_in     = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub_in   = 1'($urandom);
`endif
        bus.in_valid = valid;
    endtask

    task automatic waitReady();
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic sub, input int hold);
        logic [W+1:0] exp;
        int cyc;
        exp = refModel(a, b, cin, sub);
        waitReady();
        bus.a_in     = a;
        bus.b_in     = b;
        bus.c_in     = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub_in   = sub;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_run", 32'(bus.in_ready), 32'd0);
        // Operands and in_valid wiggle during RUN and must be ignored.
        driveJunk(1'b1);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!bus.out_valid && cyc < 3 * NIBBLES);
        bus.in_valid = 1'b0;
        checkOutput("latency", 32'(cyc), 32'(NIBBLES));
        checkOutput("sum", 32'(bus.sum_out), 32'(exp[W-1:0]));
        checkOutput("cout", 32'(bus.cout_out), 32'(exp[W]));
        checkOutput("ovf", 32'(bus.ovf_out), 32'(exp[W+1]));
        for (int h = 0; h < hold; h++) begin
            driveJunk(1'b1);
            @(negedge clk);
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold_sum", 32'(bus.sum_out), 32'(exp[W-1:0]));
            checkOutput("hold_flags", 32'({bus.ovf_out, bus.cout_out}), 32'(exp[W+1:W]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("release_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic sub_sel;
        logic [W-1:0] ra, rb;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.c_in      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub_in    = 1'b0;
`endif
        #3;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_sum", 32'(bus.sum_out), 32'd0);
        checkOutput("rst_flags", 32'({bus.ovf_out, bus.cout_out}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        applyStimulus(16'hB7A3, 16'h7F5E, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h000F, 16'h0000, 1'b1, 1'b0, 1);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 5);

        $display("[TB] reset during RUN");
        waitReady();
        bus.a_in     = 16'hFFFF;
        bus.b_in     = 16'hFFFF;
        bus.c_in     = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_sum", 32'(bus.sum_out), 32'd0);
        checkOutput("abort_flags", 32'({bus.ovf_out, bus.cout_out}), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        $display("[TB] subtract vectors");
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
`endif

        $display("[TB] random vectors");
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h7FFF;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sub_sel = 1'($urandom);
`else
            sub_sel = 1'b0;
`endif
            applyStimulus(ra, rb, 1'($urandom), sub_sel, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
